dcache_wt: RTL and testbench
============================

# dcache_wt

Parametrised direct-mapped, write-through, no-write-allocate data cache between the `mipscore` MEM stage (`exmem_alu_output`, `exmem_memread`, `exmem_memwrite`, `exmem_write_data`, `read_data_from_dcache`) and a slower backing word memory. It replaces the single-cycle `Data_memory`. It adds:
- a `stall` output to the core;
- multi-word line refill over a req/ack handshake;
- a whole-cache flush.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width; fixed at 32 in this generation
- `LINES`, 64, number of cache lines; power of two, ≥2
- `LINE_WORDS`, 4, words per line; power of two, ≥1

Ports (`clk` is the single clock; `reset` is synchronous, active-low):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-low reset
- `addr`  in  ADDR_W  core byte address; bits [1:0] ignored
- `memread`  in  1  core load request
- `memwrite`  in  1  core store request; wins if both are high
- `write_data`  in  DATA_W  store data
- `read_data`  out  DATA_W  load data; valid when `stall`=0 on a read
- `stall`  out  1  core must hold its MEM stage
- `flush`  in  1  single-cycle pulse, invalidate all lines
- `mem_req`  out  1  backing-memory request
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  word-aligned byte address
- `mem_wdata`  out  DATA_W  write data
- `mem_ack`  in  1  single-cycle completion pulse
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`

## Operation
- Address split:
  - OFF = log2(LINE_WORDS) + 2 bits of line offset (word select above the byte bits);
  - IDX = log2(LINES) bits of index;
  - TAG = ADDR_W − IDX − OFF bits.
- Per line: valid bit, tag, LINE_WORDS data words.
- `hit` = valid[idx] && tag[idx] == addr tag.
- FSM states:
  - IDLE → FILL on read miss.
  - IDLE → WRITE on any write.
  - FILL → IDLE after the last fill ack.
  - WRITE → RESP on ack.
  - RESP → IDLE unconditionally.
- IDLE:
  - Read hit: `read_data` = cached word combinationally, `stall`=0.
  - Read miss or write: `stall`=1 in the same cycle (combinational), transition taken at the clock edge.
  - No request: `stall`=0, `read_data`=0.
- FILL:
  - Issues LINE_WORDS sequential word reads, line base + 4·i, i = 0..LINE_WORDS−1.
  - Each ack writes `mem_rdata` into word i.
  - On the last ack, set valid and tag, then go to IDLE. The replayed read then hits.
  - `stall`=1 throughout FILL.
- WRITE:
  - Single write-through request with `mem_addr` = addr & ~3 and `mem_wdata` = write_data.
  - On ack: if hit, update the cached word. A miss does not allocate.
  - `stall`=1 throughout WRITE.
- RESP: `stall`=0 for exactly one cycle so the core retires the store. No new request is evaluated until IDLE.
- Handshake rules:
  - `mem_req` rises on the clock edge entering FILL or WRITE.
  - `mem_addr`, `mem_we` and `mem_wdata` are held stable while `mem_req`=1.
  - `mem_req` drops on the cycle after an ack when the FSM leaves FILL or WRITE. Between fill words it stays high with the address advanced.
  - An ack seen while `mem_req`=0 is ignored.
- Flush:
  - Honoured only in IDLE; clears every valid bit in one cycle; takes priority over a new request in that cycle (`stall`=1 for that cycle).
  - A flush in any other state is dropped. The core never flushes during a stall.

## Timing
- Reset values: state IDLE, all valid bits 0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, fill counter 0. `stall` and `read_data` follow the IDLE rules, and are 0 while `reset`=0.
- Read hit latency: 0 cycles.
- Read miss penalty: Σ(ack latencies) + 1 cycle (the IDLE replay).
- Store cost: ack latency + 1 (RESP).
- Reset asserted mid-FILL or mid-WRITE: the next edge returns all state to reset values. The partial line stays invalid and `mem_req` drops. The backing memory must tolerate an abandoned request.
- Fill counter wraps at LINE_WORDS−1. LINE_WORDS=1 degenerates to a single-read fill.

## Structure
- Package `dcache_pkg`:
  - state enum {IDLE, FILL, WRITE, RESP};
  - functions computing OFF/IDX/TAG widths from the parameters.
- Sub-module `dcache_array`:
  - valid/tag/data storage;
  - combinational read port;
  - one synchronous word-write port;
  - synchronous clear of all valid bits, used for reset and flush.
- The top holds the FSM, fill counter and handshake logic.

## Test plan
Defaults apply; the memory model acks 2 cycles after `mem_req` rises and holds mem[a] = a ^ 32'hA5A5_0000.
- Read 0x0000_0040 cold: `stall` high for 9 cycles, 4 fill reads 0x40, 0x44, 0x48, 0x4C; then `read_data` = 0xA5A5_0040 with `stall`=0.
- Repeat read of 0x44 after that fill: hit, `stall`=0, `read_data` = 0xA5A5_0044, no `mem_req`.
- Store 0xDEAD_BEEF to 0x48 (resident): one write request; RESP cycle with `stall`=0; a later read of 0x48 hits and returns 0xDEAD_BEEF.
- Store to 0x1000 (not resident): write request issued, no allocation; a later read of 0x1000 misses and fills.
- Read 0x0000_1040 (same index as 0x40, different tag): evicts the line. A later read of 0x40 misses again.
- Pulse `flush` in IDLE, then read 0x44: miss. Separately, `reset`=0 during the 3rd fill ack: `mem_req`=0 next cycle; after reset, a read of 0x40 misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-geometry helpers for the write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int lines, input int line_words);
      return addr_w - idx_w(lines) - off_w(line_words);
   endfunction

   // Word-select width, kept at least one bit so single-word lines still have a port.
   function automatic int wsel_w(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 1;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read, one synchronous word write,
// one synchronous tag install and a one-cycle clear of every valid bit.
module dcache_array #(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4,
   parameter int DATA_W     = 32,
   parameter int IDX_W      = 6,
   parameter int TAG_W      = 22,
   parameter int WSEL_W     = 2
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic [IDX_W-1:0]  i_rd_idx,
   input  logic [WSEL_W-1:0] i_rd_wsel,
   output logic              o_rd_valid,
   output logic [TAG_W-1:0]  o_rd_tag,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [WSEL_W-1:0] i_wr_wsel,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_tag_en,
   input  logic [IDX_W-1:0]  i_tag_idx,
   input  logic [TAG_W-1:0]  i_tag
);

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [DATA_W-1:0] r_data [LINES][LINE_WORDS];

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx][i_rd_wsel];

   // Clear wins over a same-cycle install so an abandoned fill never turns valid.
   always_ff @(posedge clk) begin
      if (i_clr)
         r_valid <= '0;
      else if (i_tag_en)
         r_valid[i_tag_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (i_tag_en)
         r_tag[i_tag_idx] <= i_tag;
   end

   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_data[i_wr_idx][i_wr_wsel] <= i_wr_data;
   end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with line refill and flush.
// IDLE: serve hits, launch miss/store | FILL: line refill | WRITE: store write-through | RESP: store retire
module dcache_wt
   import dcache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              stall,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int OFF_W  = off_w(LINE_WORDS);
   localparam int IDX_W  = idx_w(LINES);
   localparam int TAG_W  = tag_w(ADDR_W, LINES, LINE_WORDS);
   localparam int WSEL_W = wsel_w(LINE_WORDS);

   state_t            r_state;
   logic [WSEL_W-1:0] r_cnt;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [IDX_W-1:0]  w_idx, w_fidx;
   logic [TAG_W-1:0]  w_tag, w_ftag, w_rd_tag;
   logic [WSEL_W-1:0] w_wsel;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_rd_valid, w_hit, w_last, w_fill_ack, w_wr_ack, w_clr, w_unused;

   assign w_idx  = addr[OFF_W +: IDX_W];
   assign w_tag  = addr[ADDR_W-1 -: TAG_W];
   assign w_fidx = r_mem_addr[OFF_W +: IDX_W];
   assign w_ftag = r_mem_addr[ADDR_W-1 -: TAG_W];
   assign w_unused = ^addr[1:0];

   if (LINE_WORDS > 1) begin : g_wsel
      assign w_wsel = addr[2 +: WSEL_W];
   end else begin : g_wsel_one
      assign w_wsel = '0;
   end

   assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
   assign w_last     = (r_cnt == WSEL_W'(LINE_WORDS - 1));
   assign w_fill_ack = reset && (r_state == FILL) && r_mem_req && mem_ack;
   assign w_wr_ack   = reset && (r_state == WRITE) && r_mem_req && mem_ack;
   assign w_clr      = !reset || ((r_state == IDLE) && flush);

   dcache_array #(
      .LINES(LINES), .LINE_WORDS(LINE_WORDS), .DATA_W(DATA_W),
      .IDX_W(IDX_W), .TAG_W(TAG_W), .WSEL_W(WSEL_W)
   ) u_array (
      .clk        (clk),
      .i_clr      (w_clr),
      .i_rd_idx   (w_idx),
      .i_rd_wsel  (w_wsel),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_fill_ack || (w_wr_ack && w_hit)),
      .i_wr_idx   (w_fill_ack ? w_fidx : w_idx),
      .i_wr_wsel  (w_fill_ack ? r_cnt : w_wsel),
      .i_wr_data  (w_fill_ack ? mem_rdata : write_data),
      .i_tag_en   (w_fill_ack && w_last),
      .i_tag_idx  (w_fidx),
      .i_tag      (w_ftag)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!flush) begin
                  if (memwrite) begin
                     r_state     <= WRITE;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     r_mem_wdata <= write_data;
                  end else if (memread && !w_hit) begin
                     r_state    <= FILL;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     r_cnt      <= '0;
                  end
               end
            end
            FILL: begin
               if (w_fill_ack) begin
                  if (w_last) begin
                     r_state   <= IDLE;
                     r_mem_req <= 1'b0;
                     r_cnt     <= '0;
                  end else begin
                     r_cnt      <= r_cnt + WSEL_W'(1);
                     r_mem_addr <= r_mem_addr + ADDR_W'(4);
                  end
               end
            end
            WRITE: begin
               if (w_wr_ack) begin
                  r_state   <= RESP;
                  r_mem_req <= 1'b0;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      stall     = 1'b0;
      read_data = '0;
      if (reset) begin
         case (r_state)
            IDLE: begin
               stall = flush || memwrite || (memread && !w_hit);
               if (!flush && !memwrite && memread && w_hit)
                  read_data = w_rd_data;
            end
            FILL, WRITE: stall = 1'b1;
            default:     stall = 1'b0;
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt against a backing memory that acks one cycle after seeing a request.
module tb_dcache_wt;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = '0;
   logic        memread = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        stall;
   logic        flush = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem_store [logic [31:0]];
   logic [31:0] log_addr[$];
   logic        log_we[$];
   logic [31:0] log_wdata[$];

   dcache_wt dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .memread    (memread),
      .memwrite   (memwrite),
      .write_data (write_data),
      .read_data  (read_data),
      .stall      (stall),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Backing memory: default contents a ^ 0xA5A50000, stores are remembered.
   always @(posedge clk) begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
         mem_ack <= 1'b1;
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_wdata.push_back(mem_wdata);
         if (mem_we)
            mem_store[mem_addr] = mem_wdata;
         else
            mem_rdata <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : (mem_addr ^ 32'hA5A5_0000);
      end
   end

   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_wdata.delete();
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int n);
      @(negedge clk);
      addr = a; memread = 1'b1; memwrite = 1'b0;
      #1;
      n = 0;
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      d = read_data;
      memread = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] wd, output int n, output logic rq);
      @(negedge clk);
      addr = a; write_data = wd; memwrite = 1'b1; memread = 1'b0;
      #1;
      n = 0;
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      rq = mem_req;
      memwrite = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", stall); end
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; addr = 32'h40; memread = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
      checks++;
      if (read_data !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", read_data); end
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
      checks++;
      if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
      checks++;
      if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
      memread = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || read_data !== 32'h0) begin
         errors++; $display("FAIL idle_quiet: stall=%b rdata=%h want 0/0", stall, read_data);
      end
   endtask

   task automatic test_cold_read();
      logic [31:0] d;
      int n;
      clear_log();
      do_read(32'h40, d, n);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL cold_stall_cycles: got %0d want 9", n); end
      checks++;
      if (d !== 32'hA5A5_0040) begin errors++; $display("FAIL cold_rdata: got %h want a5a50040", d); end
      checks++;
      if (log_addr.size() !== 4) begin errors++; $display("FAIL cold_req_count: got %0d want 4", log_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_addr.size() <= i || log_addr[i] !== 32'h40 + 32'(4 * i) || log_we[i] !== 1'b0) begin
            errors++;
            $display("FAIL cold_fill_addr%0d: got %h want %h read", i,
                     (log_addr.size() > i) ? log_addr[i] : 32'hx, 32'h40 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_hit();
      logic [31:0] d;
      int n;
      clear_log();
      do_read(32'h44, d, n);
      checks++;
      if (n !== 0) begin errors++; $display("FAIL hit_stall: got %0d want 0", n); end
      checks++;
      if (d !== 32'hA5A5_0044) begin errors++; $display("FAIL hit_rdata: got %h want a5a50044", d); end
      do_read(32'h4C, d, n);
      checks++;
      if (n !== 0 || d !== 32'hA5A5_004C) begin
         errors++; $display("FAIL hit_last_word: stall=%0d rdata=%h want 0/a5a5004c", n, d);
      end
      checks++;
      if (log_addr.size() !== 0) begin errors++; $display("FAIL hit_no_req: got %0d want 0", log_addr.size()); end
   endtask

   task automatic test_store_hit();
      logic [31:0] d;
      int n;
      logic rq;
      clear_log();
      do_write(32'h48, 32'hDEAD_BEEF, n, rq);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL st_hit_stall: got %0d want 3", n); end
      checks++;
      if (rq !== 1'b0) begin errors++; $display("FAIL st_resp_req: got %b want 0", rq); end
      checks++;
      if (log_addr.size() !== 1 || log_addr[0] !== 32'h48 || log_we[0] !== 1'b1 || log_wdata[0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL st_hit_req: got n=%0d addr=%h we=%b data=%h want 1/48/1/deadbeef",
                  log_addr.size(), log_addr[0], log_we[0], log_wdata[0]);
      end
      do_read(32'h48, d, n);
      checks++;
      if (n !== 0 || d !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL st_hit_readback: stall=%0d rdata=%h want 0/deadbeef", n, d);
      end
   endtask

   task automatic test_store_miss();
      logic [31:0] d;
      int n;
      logic rq;
      clear_log();
      do_write(32'h1000, 32'h1234_5678, n, rq);
      checks++;
      if (n !== 3 || log_addr.size() !== 1 || log_addr[0] !== 32'h1000) begin
         errors++; $display("FAIL st_miss_req: stall=%0d reqs=%0d want 3/1", n, log_addr.size());
      end
      clear_log();
      do_read(32'h1000, d, n);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL st_miss_noalloc: got %0d stall cycles want 9", n); end
      checks++;
      if (d !== 32'h1234_5678) begin errors++; $display("FAIL st_miss_rdata: got %h want 12345678", d); end
      checks++;
      if (log_addr.size() !== 4 || log_addr[0] !== 32'h1000) begin
         errors++; $display("FAIL st_miss_fill: got %0d reqs want 4", log_addr.size());
      end
   endtask

   task automatic test_evict();
      logic [31:0] d;
      int n;
      do_read(32'h1040, d, n);
      checks++;
      if (n !== 9 || d !== 32'hA5A5_1040) begin
         errors++; $display("FAIL evict_fill: stall=%0d rdata=%h want 9/a5a51040", n, d);
      end
      do_read(32'h40, d, n);
      checks++;
      if (n !== 9 || d !== 32'hA5A5_0040) begin
         errors++; $display("FAIL evict_remiss: stall=%0d rdata=%h want 9/a5a50040", n, d);
      end
      do_read(32'h1004, d, n);
      checks++;
      if (n !== 0 || d !== 32'hA5A5_1004) begin
         errors++; $display("FAIL other_line_kept: stall=%0d rdata=%h want 0/a5a51004", n, d);
      end
   endtask

   task automatic test_flush();
      logic [31:0] d;
      int n;
      do_read(32'h44, d, n);
      checks++;
      if (n !== 0) begin errors++; $display("FAIL pre_flush_hit: got %0d want 0", n); end
      pulse_flush();
      do_read(32'h44, d, n);
      checks++;
      if (n !== 9 || d !== 32'hA5A5_0044) begin
         errors++; $display("FAIL flush_miss: stall=%0d rdata=%h want 9/a5a50044", n, d);
      end
      do_read(32'h1004, d, n);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL flush_all_lines: got %0d want 9", n); end
   endtask

   task automatic test_reset_mid_fill();
      logic [31:0] d;
      int n;
      int acks;
      pulse_flush();
      clear_log();
      @(negedge clk);
      addr = 32'h40; memread = 1'b1;
      acks = 0; n = 0;
      while (acks < 3 && n < 50) begin
         @(negedge clk);
         #1;
         if (mem_ack) acks++;
         n++;
      end
      checks++;
      if (acks !== 3) begin errors++; $display("FAIL mid_fill_acks: got %0d want 3", acks); end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         errors++; $display("FAIL mid_fill_drop: req=%b addr=%h want 0/0", mem_req, mem_addr);
      end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL mid_fill_stall: got %b want 0", stall); end
      memread = 1'b0;
      reset = 1'b1;
      checks++;
      if (log_addr.size() !== 3) begin errors++; $display("FAIL mid_fill_reqs: got %0d want 3", log_addr.size()); end
      do_read(32'h40, d, n);
      checks++;
      if (n !== 9 || d !== 32'hA5A5_0040) begin
         errors++; $display("FAIL post_rst_miss: stall=%0d rdata=%h want 9/a5a50040", n, d);
      end
      do_read(32'h48, d, n);
      checks++;
      if (n !== 0 || d !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL back_to_back_hit: stall=%0d rdata=%h want 0/deadbeef", n, d);
      end
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_hit();
      test_store_hit();
      test_store_miss();
      test_evict();
      test_flush();
      test_reset_mid_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
